// File: rtl/pc_btb_if.sv
// Fetch/resolve bus of the next-PC unit with its branch target buffer.
// The master is the surrounding pipeline (or a bench) and the slave is pc_btb.
//
// Handshake: i_ex_vld qualifies every i_ex_* field in the cycle it is high.
// There is no ready; the unit accepts one resolution every cycle, so a
// resolution is consumed at the clock edge that ends the cycle it is
// presented in. All o_* outputs are valid in every cycle and need no
// qualifier (o_pred_target is only meaningful while o_pred_taken is high).
interface pc_btb_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             i_stall;
    logic [XLEN-1:0]  o_imem_raddr;
    logic             o_pred_taken;
    logic [XLEN-1:0]  o_pred_target;
    logic             i_ex_vld;
    logic             i_ex_jump;
    logic [XLEN-1:0]  i_ex_pc;
    logic             i_ex_taken;
    logic [XLEN-1:0]  i_ex_target;
    logic             i_ex_pred_taken;
    logic [XLEN-1:0]  i_ex_pred_target;
    logic             o_flush;
    logic [XLEN-1:0]  o_nxt_pc;
    logic [CNT_W-1:0] o_br_cnt;
    logic [CNT_W-1:0] o_mp_cnt;

    modport master (
        output i_stall, i_ex_vld, i_ex_jump, i_ex_pc, i_ex_taken, i_ex_target,
               i_ex_pred_taken, i_ex_pred_target,
        input  o_imem_raddr, o_pred_taken, o_pred_target, o_flush, o_nxt_pc,
               o_br_cnt, o_mp_cnt
    );

    modport slave (
        input  i_stall, i_ex_vld, i_ex_jump, i_ex_pc, i_ex_taken, i_ex_target,
               i_ex_pred_taken, i_ex_pred_target,
        output o_imem_raddr, o_pred_taken, o_pred_target, o_flush, o_nxt_pc,
               o_br_cnt, o_mp_cnt
    );
endinterface

// File: rtl/pc_btb.sv
// Program counter with a direct-mapped BTB and 2-bit direction counters.
// Predicts the next fetch address from the PC register, redirects and flushes
// on an EX mispredict, and counts resolved transfers and mispredicts.
// Single-cycle datapath: there is no FSM, the only state is the PC, the BTB
// arrays and the two performance counters.
module pc_btb #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter int              DEPTH      = 16,
    parameter int              CNT_W      = 32
) (
    input  logic   i_clk,
    input  logic   i_rst,
    pc_btb_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  nxt_pc;
    logic [DEPTH-1:0] vld_q;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [XLEN-1:0]  tgt_q [DEPTH];
    logic [1:0]       ctr_q [DEPTH];
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mp_cnt_q;

    // Fetch-side lookup, purely combinational on the PC register.
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             pred_taken;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  pred_target;

    assign f_idx      = pc_q[IDX_W+1:2];
    assign f_tag      = pc_q[XLEN-1:IDX_W+2];
    assign f_hit      = vld_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken = f_hit && ctr_q[f_idx][1];
    assign pc_plus4   = pc_q + FOUR;
    // A weak (not-taken) hit falls through, so the target only comes from the
    // BTB when the prediction is taken; otherwise fetch continues sequentially.
    assign pred_target = pred_taken ? tgt_q[f_idx] : pc_plus4;

    // EX-side resolution. Jumps are always taken; target bit 0 is dropped so
    // jalr results land on a halfword boundary.
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;
    logic             tk;
    logic [XLEN-1:0]  tgt;
    logic [XLEN-1:0]  actual;
    logic             mispredict;

    assign e_idx      = bus.i_ex_pc[IDX_W+1:2];
    assign e_tag      = bus.i_ex_pc[XLEN-1:IDX_W+2];
    assign e_hit      = vld_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign tk         = bus.i_ex_jump || bus.i_ex_taken;
    assign tgt        = bus.i_ex_target & ~XLEN'(1);
    assign actual     = tk ? tgt : (bus.i_ex_pc + FOUR);
    assign mispredict = bus.i_ex_vld &&
                        ((tk != bus.i_ex_pred_taken) ||
                         (tk && (tgt != bus.i_ex_pred_target)));

    // Next-PC select: reset, then redirect, then stall-hold, then prediction.
    always_comb begin
        nxt_pc = pred_target;
        if (i_rst) begin
            nxt_pc = RESET_ADDR;
        end else if (mispredict) begin
            nxt_pc = actual;
        end else if (bus.i_stall) begin
            nxt_pc = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= nxt_pc;
        end
    end

    // BTB training from EX; runs regardless of stall, and the fetch lookup in
    // the same cycle still sees the pre-update contents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i] <= 1'b0;
                ctr_q[i] <= 2'b01;
            end
        end else if (bus.i_ex_vld) begin
            if (e_hit) begin
                if (bus.i_ex_jump) begin
                    tgt_q[e_idx] <= tgt;
                    ctr_q[e_idx] <= 2'b11;
                end else if (tk) begin
                    tgt_q[e_idx] <= tgt;
                    if (ctr_q[e_idx] != 2'b11) ctr_q[e_idx] <= ctr_q[e_idx] + 2'd1;
                end else begin
                    if (ctr_q[e_idx] != 2'b00) ctr_q[e_idx] <= ctr_q[e_idx] - 2'd1;
                end
            end else if (tk) begin
                vld_q[e_idx] <= 1'b1;
                tag_q[e_idx] <= e_tag;
                tgt_q[e_idx] <= tgt;
                ctr_q[e_idx] <= bus.i_ex_jump ? 2'b11 : 2'b10;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (bus.i_ex_vld && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + CNT_W'(1);
            if (mispredict && (mp_cnt_q != '1)) mp_cnt_q <= mp_cnt_q + CNT_W'(1);
        end
    end

    assign bus.o_imem_raddr  = pc_q;
    assign bus.o_pred_taken  = pred_taken;
    assign bus.o_pred_target = pred_target;
    assign bus.o_flush       = mispredict;
    assign bus.o_nxt_pc      = nxt_pc;
    assign bus.o_br_cnt      = br_cnt_q;
    assign bus.o_mp_cnt      = mp_cnt_q;
endmodule
